// File: rtl/alu_mux_pkg.sv
// Shared definitions for the ALU result-select pipeline: default geometry and
// the skid buffer state encoding.
package alu_mux_pkg;

  localparam int ALU_MUX_WIDTH  = 8;
  localparam int ALU_MUX_NUM_IN = 4;
  localparam int ALU_MUX_SEL_W  = 3;

  // Buffer occupancy: EMPTY = nothing held, ONE = main only, FULL = main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  // True when a select value addresses one of the num_in operands.
  function automatic logic sel_in_range(input int sel, input int num_in);
    return (sel < num_in);
  endfunction

endpackage

// File: rtl/alu_mux_skid.sv
// Two-entry skid buffer (main output register plus one skid register).
//
// Handshake: a beat moves upstream->buffer on an edge where i_valid && o_ready,
// and buffer->downstream on an edge where o_valid && i_ready. o_ready and
// o_valid both come straight from flops, so neither has a combinational path
// from the opposite side of the buffer. Payload on o_payload is held stable
// while o_valid && !i_ready.
module alu_mux_skid
  import alu_mux_pkg::*;
#(
  parameter int PW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] i_payload,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [PW-1:0] o_payload,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [1:0]    o_dbg_state
);

  skid_state_e r_state;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic r_out_valid;
  logic r_in_ready;

  logic w_accept;
  logic w_deliver;

  assign w_accept  = i_valid & r_in_ready;
  assign w_deliver = r_out_valid & i_ready;

  // Occupancy state machine; valid/ready flags are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main      <= i_payload;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            // Main drains and reloads on the same edge.
            r_main <= i_payload;
          end else if (w_accept) begin
            // Downstream stalled: park the new beat behind main.
            r_skid     <= i_payload;
            r_in_ready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (w_deliver) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // o_ready is low here, so only a delivery can happen.
          if (w_deliver) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_EMPTY;
        end
      endcase
    end
  end

  assign o_ready     = r_in_ready;
  assign o_valid     = r_out_valid;
  assign o_payload   = r_main;
  assign o_dbg_state = r_state;

endmodule

// File: rtl/alu_result_mux_pipe.sv
// Registered ALU result-select mux with a valid/ready skid buffer.
// Picks one of NUM_IN operands by in_sel, flags out-of-range selects per beat
// and keeps a sticky error bit.
// Optional: define ALU_MUX_ERRCNT_EN to add the saturating err_count output.
module alu_result_mux_pipe
  import alu_mux_pkg::*;
#(
  parameter int WIDTH  = ALU_MUX_WIDTH,
  parameter int NUM_IN = ALU_MUX_NUM_IN,
  parameter int SEL_W  = ALU_MUX_SEL_W
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic [1:0]              dbg_state,
  output logic                    err_sticky
`ifdef ALU_MUX_ERRCNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  // Reject geometries the select path cannot represent.
  if (NUM_IN < 2 || (2 ** SEL_W) < NUM_IN) begin : g_bad_params
    $fatal(1, "alu_result_mux_pipe: need NUM_IN >= 2 and 2**SEL_W >= NUM_IN");
  end

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_ok;
  logic             w_accept;
  logic             w_bad_accept;
  logic [WIDTH:0]   w_skid_in;
  logic [WIDTH:0]   w_skid_out;

  logic r_err_sticky;

  // Operand select; out-of-range selects yield zero data and a beat error.
  always_comb begin
    w_sel_data = '0;
    w_sel_ok   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_in_range(int'(in_sel), NUM_IN) && (int'(in_sel) == k)) begin
        w_sel_data = in_data[k*WIDTH +: WIDTH];
        w_sel_ok   = 1'b1;
      end
    end
  end

  // Error flag travels with the data as the top bit of the buffered payload.
  assign w_skid_in    = {~w_sel_ok, w_sel_data};
  assign w_accept     = in_valid & in_ready;
  assign w_bad_accept = w_accept & ~w_sel_ok;

  alu_mux_skid #(
    .PW(WIDTH + 1)
  ) u_skid (
    .clk        (CLK),
    .rst        (RESET),
    .i_payload  (w_skid_in),
    .i_valid    (in_valid),
    .o_ready    (in_ready),
    .o_payload  (w_skid_out),
    .o_valid    (out_valid),
    .i_ready    (out_ready),
    .o_dbg_state(dbg_state)
  );

  assign out_data = w_skid_out[WIDTH-1:0];
  assign out_err  = w_skid_out[WIDTH];

  // Sticky error: a bad accept on the same edge as err_clr keeps it set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_err_sticky <= 1'b0;
    end else if (w_bad_accept) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign err_sticky = r_err_sticky;

`ifdef ALU_MUX_ERRCNT_EN
  logic [7:0] r_err_count;

  // Saturating count of bad accepts; an increment with err_clr restarts at 1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_err_count <= 8'd0;
    end else if (w_bad_accept && err_clr) begin
      r_err_count <= 8'd1;
    end else if (w_bad_accept) begin
      if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end else if (err_clr) begin
      r_err_count <= 8'd0;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_alu_result_mux_pipe.sv
// Directed bench for alu_result_mux_pipe: reset state, select path, skid
// stalls, sticky error, ordered streaming under back-pressure and mid-stream
// reset. Inputs change and outputs are sampled 1 time unit after each rising
// edge.
module tb_alu_result_mux_pipe;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 3;

  logic                    CLK;
  logic                    RESET;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_clr;
  logic [1:0]              dbg_state;
  logic                    err_sticky;
`ifdef ALU_MUX_ERRCNT_EN
  logic [7:0]              err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  alu_result_mux_pipe #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .dbg_state (dbg_state),
    .err_sticky(err_sticky)
`ifdef ALU_MUX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  // Clock block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Driver for one upstream beat value
  task automatic drive_beat(input logic v, input logic [SEL_W-1:0] s);
    in_valid = v;
    in_sel   = s;
  endtask

  initial begin : stim
    int accepted;
    int cycles;
    int bad_cnt;
    logic [WIDTH-1:0] exp_b;
    logic rdy_before;
    logic [WIDTH-1:0] bytes[4];

    RESET     = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (2) step();
    RESET = 1'b0;
    step();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);

    // Single beat, sel=2 -> 8'h33 one cycle later
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    drive_beat(1'b1, 3'd2);
    step();
    drive_beat(1'b0, 3'd1);
    check("sel2_data", 32'(out_data), 32'h33);
    check("sel2_valid", 32'(out_valid), 32'd1);
    check("sel2_err", 32'(out_err), 32'd0);
    step();
    check("sel2_drained", 32'(out_valid), 32'd0);

    // Changing in_sel while idle has no effect
    drive_beat(1'b0, 3'd3);
    step();
    check("idle_sel_no_beat", 32'(out_valid), 32'd0);

    // Back-pressure: fill main then skid
    out_ready = 1'b0;
    drive_beat(1'b1, 3'd0);
    step();
    check("fill1_in_ready", 32'(in_ready), 32'd1);
    check("fill1_data", 32'(out_data), 32'h11);
    drive_beat(1'b1, 3'd3);
    step();
    drive_beat(1'b0, 3'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_state", 32'(dbg_state), 32'd2);
    check("full_hold_data", 32'(out_data), 32'h11);
    step();
    check("stall_hold_data", 32'(out_data), 32'h11);
    check("stall_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("drain_second", 32'(out_data), 32'h44);
    check("drain_second_valid", 32'(out_valid), 32'd1);
    check("drain_in_ready", 32'(in_ready), 32'd1);
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Out-of-range select and sticky error
    drive_beat(1'b1, 3'd5);
    step();
    drive_beat(1'b0, 3'd0);
    check("bad_data", 32'(out_data), 32'd0);
    check("bad_err", 32'(out_err), 32'd1);
    check("bad_sticky", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    step();
    check("clr_sticky", 32'(err_sticky), 32'd0);
    drive_beat(1'b1, 3'd5);
    step();
    err_clr = 1'b0;
    drive_beat(1'b0, 3'd0);
    check("clr_vs_set_sticky", 32'(err_sticky), 32'd1);
`ifdef ALU_MUX_ERRCNT_EN
    check("cnt_inc_wins_clr", 32'(err_count), 32'd1);
`endif
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_again", 32'(err_sticky), 32'd0);
    check("idle_again", 32'(out_valid), 32'd0);

    // Stream 20 beats with random back-pressure; scoreboard checks order
    void'($urandom(32'd1234));
    accepted = 0;
    cycles   = 0;
    bad_cnt  = 0;
    exp_q.delete();
    while ((accepted < 20 || exp_q.size() != 0) && cycles < 400) begin
      for (int k = 0; k < NUM_IN; k++) bytes[k] = WIDTH'($urandom_range(0, 255));
      in_data  = {bytes[3], bytes[2], bytes[1], bytes[0]};
      in_sel   = 3'(accepted % 4);
      in_valid = (accepted < 20);
      rdy_before = in_ready;
      out_ready  = 1'b1;
      #1;
      if (in_ready !== rdy_before) bad_cnt++;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_ready !== rdy_before) bad_cnt++;
      if (in_valid && in_ready) begin
        exp_q.push_back(bytes[accepted % 4]);
        accepted++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_beat", 32'(out_data), 32'hDEAD);
        end else begin
          exp_b = exp_q.pop_front();
          check("stream_data", 32'(out_data), 32'(exp_b));
          check("stream_err", 32'(out_err), 32'd0);
        end
      end
      step();
      cycles++;
    end
    in_valid = 1'b0;
    check("stream_done_in_budget", 32'(cycles < 400), 32'd1);
    check("stream_all_accepted", 32'(accepted), 32'd20);
    check("in_ready_no_comb_path", 32'(bad_cnt), 32'd0);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while FULL discards both beats
    out_ready = 1'b0;
    drive_beat(1'b1, 3'd1);
    step();
    drive_beat(1'b1, 3'd2);
    step();
    drive_beat(1'b0, 3'd0);
    check("pre_rst_full", 32'(in_ready), 32'd0);
    RESET = 1'b1;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    step();
    RESET = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    step();
    check("no_stale_beat", 32'(out_valid), 32'd0);
`ifdef ALU_MUX_ERRCNT_EN
    check("cnt_after_rst", 32'(err_count), 32'd0);

    // Saturation: 260 accepted bad beats
    drive_beat(1'b1, 3'd7);
    repeat (260) step();
    drive_beat(1'b0, 3'd0);
    check("cnt_saturated", 32'(err_count), 32'd255);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("cnt_cleared", 32'(err_count), 32'd0);
`endif

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_result_mux_pipe.md
Name: alu_result_mux_pipe

Overview:
- Parametrised, registered successor to the combinational ALU result-select mux.
- Selects one of NUM_IN WIDTH-bit operands by opcode-derived select, then registers the result.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the ALU-to-writeback path can stall without losing a beat.
- Flags out-of-range selects per beat and keeps a sticky error bit.

Parameters:
- WIDTH, 8, operand/result width in bits.
- NUM_IN, 4, number of selectable inputs (2..16).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  select for the current beat.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- out_data  output  WIDTH  selected, registered result.
- out_err  output  1  this output beat had in_sel >= NUM_IN.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- err_clr  input  1  synchronous clear of err_sticky.
- err_sticky  output  1  set by any accepted out-of-range select.

Behaviour:
- Reset is asynchronous: out_data=0, out_err=0, out_valid=0, err_sticky=0, skid register empty, in_ready=1 on the first clock after RESET deasserts.
- Accept on in_valid && in_ready. Deliver on out_valid && out_ready.
- Select path:
  - in_sel < NUM_IN: captured value = in_data[in_sel*WIDTH +: WIDTH], beat error = 0.
  - in_sel >= NUM_IN: captured value = 0, beat error = 1.
- Latency is 1 cycle: a beat accepted at edge N is on out_data/out_valid after edge N when the output register is empty or draining.
- Storage is a main (output) register plus one skid register. State machine:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- Transitions:
  - EMPTY, accept -> ONE.
  - ONE, accept & deliver -> ONE (main reloads).
  - ONE, accept & !deliver -> FULL (beat goes to skid).
  - ONE, deliver & !accept -> EMPTY.
  - FULL, deliver -> ONE (skid moves to main).
  - Accept is impossible in FULL.
- in_ready = (state != FULL). It is driven from a register only; no combinational path from out_ready.
- Beat order is preserved. No beat is dropped or duplicated.
- out_data and out_err stay stable while out_valid && !out_ready.
- err_sticky:
  - Set on the edge that accepts a beat with in_sel >= NUM_IN.
  - Cleared by err_clr; set wins if both occur on the same edge.
- in_data/in_sel are ignored when not accepted. Changing in_sel while in_valid=0 has no effect.
- RESET mid-stream discards both buffered beats immediately; out_valid falls asynchronously.
- Elaboration check: NUM_IN < 2 or 2**SEL_W < NUM_IN is a fatal error.

Optional Feature:
- Macro: ALU_MUX_ERRCNT_EN.
- Defined: adds output err_count [7:0].
  - Saturating count of accepted out-of-range beats; holds at 255.
  - Reset to 0 by RESET and by err_clr.
  - Increment wins over err_clr on the same edge, giving result 1.
- Undefined: the port is absent and no counter logic exists.

Decomposition:
- Shared package alu_mux_pkg holds:
  - Defaults ALU_MUX_WIDTH=8, ALU_MUX_NUM_IN=4, ALU_MUX_SEL_W=3.
  - State encoding constants ST_EMPTY=2'b00, ST_ONE=2'b01, ST_FULL=2'b10.
- Natural sub-module: alu_mux_skid (WIDTH+1-bit payload skid buffer, state machine and handshake). The top level holds the select logic, error flag and optional counter.

Test Plan:
- Reset, then inputs {8'h11,8'h22,8'h33,8'h44}, in_sel=2, in_valid=1, out_ready=1 for one cycle -> next cycle out_data=8'h33, out_valid=1, out_err=0.
- out_ready=0; accept sel=0 then sel=3 -> in_ready=0 after second accept; out_data holds 8'h11; raise out_ready -> 8'h11 then 8'h44 on consecutive cycles, then out_valid=0.
- in_sel=5 accepted -> out_data=0, out_err=1, err_sticky=1; pulse err_clr -> err_sticky=0; err_clr together with another sel=5 accept -> err_sticky stays 1.
- Stream 20 beats, sel cycling 0..3, out_ready toggled randomly (seed fixed) -> outputs match the input order exactly; in_ready never depends combinationally on out_ready.
- Assert RESET while in FULL -> out_valid=0 immediately; after release in_ready=1; no stale beat appears.
- ALU_MUX_ERRCNT_EN defined: 260 accepted beats with sel=7 -> err_count saturates at 255; err_clr -> 0.
